// File: rtl/m6809_core_alu_seq.sv
// 6809 wide ALU with registered results/flags and a multi-cycle shift-add MUL.
// Single-cycle ops report done one cycle after start; MUL iterates H cycles first.
module m6809_core_alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] alu_in_a,
    input  logic [WIDTH-1:0] alu_in_b,
    input  logic             c_in,
    input  logic             v_in,
    input  logic             n_in,
    input  logic             h_in,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [WIDTH-1:0] alu_out,
    output logic             c_out,
    output logic             z_out,
    output logic             n_out,
    output logic             v_out,
    output logic             h_out
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned CW = $clog2(H + 1);

    localparam logic [2:0] OP_TST = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_CMP = 3'd3;
    localparam logic [2:0] OP_SEX = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             accept_c;
    logic             finish_c;
    logic             mul_step_c;

    logic [H-1:0]     mcand_q;
    logic [H-1:0]     mplr_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    count_q;
    logic             n_lat_q;
    logic             v_lat_q;
    logic             h_lat_q;

    logic [H-1:0]     addend_c;
    logic [H:0]       mul_sum_c;
    logic [WIDTH-1:0] acc_nx_c;

    logic [WIDTH:0]   add_c;
    logic [WIDTH:0]   sub_c;
    logic [WIDTH-1:0] sex_c;

    logic [WIDTH-1:0] res_c;
    logic             res_cf_c;
    logic             res_vf_c;
    logic             res_nf_c;
    logic             res_hf_c;
    logic             res_wr_c;

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nx   = state;
        accept_c   = 1'b0;
        finish_c   = 1'b0;
        mul_step_c = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (op == OP_MUL) begin
                        state_nx = S_MUL;
                    end else begin
                        state_nx = S_DONE;
                        finish_c = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_step_c = 1'b1;
                if (count_q == CW'(1)) begin
                    state_nx = S_DONE;
                    finish_c = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // One shift-add step: add multiplicand into the upper half, then shift right with carry
    always_comb begin
        addend_c  = mplr_q[0] ? mcand_q : '0;
        mul_sum_c = {1'b0, acc_q[WIDTH-1:H]} + {1'b0, addend_c};
        acc_nx_c  = {mul_sum_c, acc_q[H-1:1]};
    end

    // Single-cycle arithmetic on the live operands
    always_comb begin
        add_c = {1'b0, alu_in_a} + {1'b0, alu_in_b};
        sub_c = {1'b0, alu_in_a} - {1'b0, alu_in_b};
        sex_c = {{H{alu_in_a[H-1]}}, alu_in_a[H-1:0]};
    end

    // Result and flag selection for whichever operation is finishing
    always_comb begin
        res_c    = alu_in_a;
        res_cf_c = c_in;
        res_vf_c = 1'b0;
        res_nf_c = alu_in_a[WIDTH-1];
        res_hf_c = h_in;
        res_wr_c = 1'b1;
        if (state == S_MUL) begin
            res_c    = acc_nx_c;
            res_cf_c = acc_nx_c[H-1];
            res_vf_c = v_lat_q;
            res_nf_c = n_lat_q;
            res_hf_c = h_lat_q;
        end else begin
            unique case (op)
                OP_ADD: begin
                    res_c    = add_c[WIDTH-1:0];
                    res_cf_c = add_c[WIDTH];
                    res_vf_c = (alu_in_a[WIDTH-1] == alu_in_b[WIDTH-1]) &&
                               (add_c[WIDTH-1] != alu_in_a[WIDTH-1]);
                    res_nf_c = add_c[WIDTH-1];
                end
                OP_SUB, OP_CMP: begin
                    res_c    = sub_c[WIDTH-1:0];
                    res_cf_c = sub_c[WIDTH];
                    res_vf_c = (alu_in_a[WIDTH-1] != alu_in_b[WIDTH-1]) &&
                               (sub_c[WIDTH-1] != alu_in_a[WIDTH-1]);
                    res_nf_c = sub_c[WIDTH-1];
                    res_wr_c = (op != OP_CMP);
                end
                OP_SEX: begin
                    res_c    = sex_c;
                    res_vf_c = v_in;
                    res_nf_c = sex_c[WIDTH-1];
                end
                default: begin
                    // TST and the reserved encodings
                    res_c    = alu_in_a;
                    res_nf_c = alu_in_a[WIDTH-1];
                end
            endcase
        end
    end

    // Datapath: MUL operands/iteration, handshake flags, registered results
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            alu_out <= '0;
            c_out   <= 1'b0;
            z_out   <= 1'b0;
            n_out   <= 1'b0;
            v_out   <= 1'b0;
            h_out   <= 1'b0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            n_lat_q <= 1'b0;
            v_lat_q <= 1'b0;
            h_lat_q <= 1'b0;
        end else begin
            busy <= (state_nx == S_MUL);
            done <= (state_nx == S_DONE);
            if (accept_c && (op == OP_MUL)) begin
                mcand_q <= alu_in_a[H-1:0];
                mplr_q  <= alu_in_b[H-1:0];
                acc_q   <= '0;
                count_q <= CW'(H);
                n_lat_q <= n_in;
                v_lat_q <= v_in;
                h_lat_q <= h_in;
            end
            if (mul_step_c) begin
                acc_q   <= acc_nx_c;
                mplr_q  <= mplr_q >> 1;
                count_q <= count_q - CW'(1);
            end
            if (finish_c) begin
                alu_out <= res_c;
                c_out   <= res_cf_c;
                z_out   <= ~|res_c;
                n_out   <= res_nf_c;
                v_out   <= res_vf_c;
                h_out   <= res_hf_c;
                wr_en   <= res_wr_c;
            end
        end
    end

`ifndef SYNTHESIS
    logic pending_q;

    // Tracks an accepted request that has not yet reported done
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pending_q <= 1'b0;
        end else if (accept_c) begin
            pending_q <= 1'b1;
        end else if (state == S_DONE) begin
            pending_q <= 1'b0;
        end
    end

    a_busy_in_mul: assert property (@(posedge clk) disable iff (!reset_b) busy |-> (state == S_MUL));
    a_done_single: assert property (@(posedge clk) disable iff (!reset_b) done |=> !done);
    a_done_start:  assert property (@(posedge clk) disable iff (!reset_b) done |-> pending_q);
`endif

endmodule

// File: tb/tb_m6809_core_alu_seq.sv
// Bench for m6809_core_alu_seq: vector table plus scoreboard, and hand sequences
// for start-during-MUL and reset-during-MUL.
module tb_m6809_core_alu_seq;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        vi;
        logic        ni;
        logic        hi;
        logic [15:0] out;
        logic        co;
        logic        zo;
        logic        no;
        logic        vo;
        logic        ho;
        logic        wr;
        int          lat;
        int          start_cyc;
    } vec_t;

    localparam int unsigned NV = 19;

    logic        clk;
    logic        reset_b;
    logic        start;
    logic [2:0]  op;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic        c_in;
    logic        v_in;
    logic        n_in;
    logic        h_in;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [15:0] alu_out;
    logic        c_out;
    logic        z_out;
    logic        n_out;
    logic        v_out;
    logic        h_out;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          busy_cnt;
    logic [15:0] last_out;
    vec_t        sb_q[$];
    vec_t        vecs[NV];

    m6809_core_alu_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .start    (start),
        .op       (op),
        .alu_in_a (alu_in_a),
        .alu_in_b (alu_in_b),
        .c_in     (c_in),
        .v_in     (v_in),
        .n_in     (n_in),
        .h_in     (h_in),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .alu_out  (alu_out),
        .c_out    (c_out),
        .z_out    (z_out),
        .n_out    (n_out),
        .v_out    (v_out),
        .h_out    (h_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pops one expectation and checks result, flags and timing
    always @(negedge clk) begin
        vec_t e;
        if (!reset_b) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("alu_out", 32'(alu_out), 32'(e.out));
                    chk("flags_czanvh", 32'({c_out, z_out, n_out, v_out, h_out}),
                        32'({e.co, e.zo, e.no, e.vo, e.ho}));
                    chk("wr_en", 32'(wr_en), 32'(e.wr));
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk("busy_cycles", 32'(busy_cnt), (e.op == 3'd5) ? 32'd8 : 32'd0);
                    last_out = e.out;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic scramble();
        op       = 3'($urandom);
        alu_in_a = 16'($urandom);
        alu_in_b = 16'($urandom);
        c_in     = 1'($urandom);
        v_in     = 1'($urandom);
        n_in     = 1'($urandom);
        h_in     = 1'($urandom);
    endtask

    task automatic drive_start(input vec_t v);
        vec_t e;
        @(negedge clk);
        start    = 1'b1;
        op       = v.op;
        alu_in_a = v.a;
        alu_in_b = v.b;
        c_in     = v.ci;
        v_in     = v.vi;
        n_in     = v.ni;
        h_in     = v.hi;
        e           = v;
        e.start_cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", 32'(sb_q.size()), 32'(0));
            sb_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        drive_start(v);
        @(negedge clk);
        start = 1'b0;
        scramble();
        wait_drain();
    endtask

    initial begin
        vec_t mv;
        n_cmp    = 0;
        n_err    = 0;
        cyc      = 0;
        busy_cnt = 0;
        last_out = 16'h0000;
        reset_b  = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        alu_in_a = 16'h0000;
        alu_in_b = 16'h0000;
        c_in     = 1'b0;
        v_in     = 1'b0;
        n_in     = 1'b0;
        h_in     = 1'b0;

        // op, a, b, c_in, v_in, n_in, h_in | out, C, Z, N, V, H, wr_en, latency, 0
        vecs[0]  = '{3'd1, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0};
        vecs[1]  = '{3'd2, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[2]  = '{3'd3, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[3]  = '{3'd5, 16'h000F, 16'h0009, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0087, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9, 0};
        vecs[4]  = '{3'd4, 16'h1280, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFF80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[5]  = '{3'd4, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[6]  = '{3'd0, 16'h8000, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[7]  = '{3'd1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[8]  = '{3'd1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0};
        vecs[9]  = '{3'd2, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[10] = '{3'd3, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
        vecs[11] = '{3'd5, 16'hABFF, 16'hCDFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9, 0};
        vecs[12] = '{3'd5, 16'h0000, 16'h0055, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9, 0};
        vecs[13] = '{3'd6, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[14] = '{3'd5, 16'h0080, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9, 0};
        vecs[15] = '{3'd7, 16'h7F00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[16] = '{3'd4, 16'h007F, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h007F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[17] = '{3'd2, 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[18] = '{3'd1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, wr_en, c_out, z_out, n_out, v_out, h_out, alu_out}), 32'(0));
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < int'(NV); i++) begin
            run_vec(vecs[i]);
        end

        // start pulsed with ADD throughout a MUL: ignored, output holds until the MUL done
        mv = '{3'd5, 16'h0033, 16'h0011, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0363, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9, 0};
        drive_start(mv);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start    = 1'b1;
            op       = 3'd1;
            alu_in_a = 16'($urandom);
            alu_in_b = 16'($urandom);
            if (i < 8) chk("hold_during_mul", 32'(alu_out), 32'(last_out));
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        // Reset in the 4th MUL cycle abandons the MUL with no done
        mv = '{3'd5, 16'h000F, 16'h0009, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0087, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9, 0};
        drive_start(mv);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'(1));
        #1;
        reset_b = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({busy, done, wr_en, c_out, z_out, n_out, v_out, h_out, alu_out}), 32'(0));
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", 32'(done), 32'(0));

        mv = '{3'd0, 16'h0000, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
        run_vec(mv);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
